// File: rtl/mux_scan_ctrl_if.sv
// Sample bus from the scan controller to downstream logic.
//   sample_valid : one-cycle pulse, sample present
//   sample_bit   : captured mux output
//   sample_ch    : channel tag of the sample
//   frame_done   : pulses with the sample of the last enabled channel
//   frame_parity : XOR of the sample bits of the last completed frame
interface mux_scan_ctrl_if;
  logic       sample_valid;
  logic       sample_bit;
  logic [1:0] sample_ch;
  logic       frame_done;
  logic       frame_parity;

  modport master (
    output sample_valid, sample_bit, sample_ch, frame_done, frame_parity
  );

  modport slave (
    input sample_valid, sample_bit, sample_ch, frame_done, frame_parity
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin channel sequencer for a 4:1 registered mux. Drives sel over the
// enabled channels, waits out the mux register latency plus a programmable
// dwell, then captures mux_out and presents it with its channel tag.
// Optional feature macro: MUX_SCAN_PARITY_EN (per-frame parity of samples).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start/stop : begin scanning (IDLE only) / end after current sample
//   mask       : channel enables, captured on accepted start
//   dwell      : extra settle cycles per channel, captured on accepted start
//   mux_out    : registered mux output
//   sel        : mux channel select (registered)
//   busy       : high whenever not IDLE
//   smp        : sample bus (master side)
module mux_scan_ctrl #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [1:0]         sel,
  output logic               busy,
  mux_scan_ctrl_if.master    smp
);

  // One extra bit so dwell+1 never wraps at the maximum dwell.
  localparam int unsigned CNT_W = DWELL_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t             state;
  logic [3:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [CNT_W-1:0]   cnt;
  logic               stop_q;
  logic               is_last_c;
  logic               stop_pend_c;

  // Lowest enabled channel in m.
  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Highest enabled channel in m.
  function automatic logic [1:0] highest_ch(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Next enabled channel after cur, ascending with wrap; cur itself if alone.
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] c;
    r = cur;
    for (int i = 3; i >= 1; i--) begin
      c = cur + 2'(i);
      if (m[c]) r = c;
    end
    return r;
  endfunction

  assign is_last_c   = (sel == highest_ch(mask_q));
  assign stop_pend_c = stop_q | stop;

`ifdef MUX_SCAN_PARITY_EN
  logic par_acc;
`else
  assign smp.frame_parity = 1'b0;
`endif

  // Scan FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      mask_q           <= '0;
      dwell_q          <= '0;
      cnt              <= '0;
      stop_q           <= 1'b0;
      sel              <= 2'd0;
      busy             <= 1'b0;
      smp.sample_valid <= 1'b0;
      smp.sample_bit   <= 1'b0;
      smp.sample_ch    <= 2'd0;
      smp.frame_done   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      smp.frame_parity <= 1'b0;
      par_acc          <= 1'b0;
`endif
    end else begin
      smp.sample_valid <= 1'b0;
      smp.frame_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && (mask != 4'd0)) begin
            mask_q  <= mask;
            dwell_q <= dwell;
            sel     <= lowest_ch(mask);
            cnt     <= CNT_W'(dwell) + CNT_W'(1);
            busy    <= 1'b1;
            stop_q  <= 1'b0;
            state   <= SETTLE;
`ifdef MUX_SCAN_PARITY_EN
            smp.frame_parity <= 1'b0;
            par_acc          <= 1'b0;
`endif
          end
        end
        SETTLE: begin
          if (stop) stop_q <= 1'b1;
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        SAMPLE: begin
          smp.sample_valid <= 1'b1;
          smp.sample_bit   <= mux_out;
          smp.sample_ch    <= sel;
          smp.frame_done   <= is_last_c;
`ifdef MUX_SCAN_PARITY_EN
          if (is_last_c) begin
            smp.frame_parity <= par_acc ^ mux_out;
            par_acc          <= 1'b0;
          end else begin
            par_acc <= par_acc ^ mux_out;
          end
`endif
          if (stop_pend_c) begin
            sel    <= 2'd0;
            busy   <= 1'b0;
            stop_q <= 1'b0;
            state  <= IDLE;
          end else begin
            sel   <= next_ch(mask_q, sel);
            cnt   <= CNT_W'(dwell_q) + CNT_W'(1);
            state <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a scoreboard of expected samples
// (arrival cycle, channel, bit, frame flags) checked by a sample monitor.
module tb_mux_scan_ctrl;
  localparam int unsigned DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [3:0]         mask = 4'd0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               mux_out;
  logic [1:0]         sel;
  logic               busy;
  logic [3:0]         data = 4'd0;
  int unsigned        cyc = 0;
  int                 checks = 0;
  int                 errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  ch;
    logic        b;
    logic        fd;
    logic        fp;
    logic        last;
  } exp_t;

  exp_t q[$];

  mux_scan_ctrl_if bus();

  mux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .mask    (mask),
    .dwell   (dwell),
    .mux_out (mux_out),
    .sel     (sel),
    .busy    (busy),
    .smp     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the downstream 4:1 registered mux.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mux_out <= 1'b0;
    else        mux_out <= data[sel];
  end

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pops the scoreboard on every sample and checks it against expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.frame_done && !bus.sample_valid) begin
        checks++; errors++;
        $display("FAIL frame_done_alone cyc=%0d frame_done=1 required sample_valid=1", cyc);
      end
      if (bus.sample_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample cyc=%0d ch=%0d", cyc, bus.sample_ch);
        end else begin
          e = q.pop_front();
          if (cyc !== e.cyc || bus.sample_ch !== e.ch || bus.sample_bit !== e.b ||
              bus.frame_done !== e.fd || bus.frame_parity !== e.fp || busy !== ~e.last) begin
            errors++;
            $display("FAIL sample got cyc=%0d ch=%0d bit=%0b fd=%0b fp=%0b busy=%0b required cyc=%0d ch=%0d bit=%0b fd=%0b fp=%0b busy=%0b",
                     cyc, bus.sample_ch, bus.sample_bit, bus.frame_done, bus.frame_parity, busy,
                     e.cyc, e.ch, e.b, e.fd, e.fp, ~e.last);
          end
        end
      end
    end
  endtask

  // Starts a scan, expects n samples, stops it during the SETTLE of sample n.
  task automatic run_scan(input logic [3:0] m, input int unsigned d, input logic [3:0] dat,
                          input int unsigned n, input bit poke);
    int unsigned p;
    int unsigned e0;
    int unsigned len;
    logic [1:0]  chans[$];
    logic [1:0]  cur;
    exp_t        e;
    logic        fp;
    p  = d + 3;
    fp = 1'b0;
    for (int c = 0; c < 4; c++) if (m[c]) chans.push_back(2'(c));
    len  = chans.size();
    data = dat;
    @(negedge clk);
    start = 1'b1; mask = m; dwell = DWELL_W'(d);
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    for (int unsigned k = 0; k < n; k++) begin
      e.cyc  = e0 + (k + 1) * p;
      e.ch   = chans[k % len];
      e.b    = dat[chans[k % len]];
      e.fd   = ((k % len) == len - 1);
`ifdef MUX_SCAN_PARITY_EN
      if (e.fd) fp = ^(dat & m);
`endif
      e.fp   = fp;
      e.last = (k == n - 1);
      q.push_back(e);
    end
    checks++;
    if (busy !== 1'b1 || sel !== chans[0]) begin
      errors++;
      $display("FAIL start_accept busy=%0b sel=%0d required busy=1 sel=%0d", busy, sel, chans[0]);
    end
    if (poke) begin
      start = 1'b1; mask = 4'b0100; dwell = '0;
      @(negedge clk);
      start = 1'b0;
    end
    wait_cyc(e0 + (n - 1) * p);
    cur = chans[(n - 1) % len];
    checks++;
    if (sel !== cur || busy !== 1'b1) begin
      errors++;
      $display("FAIL settle_sel sel=%0d busy=%0b required sel=%0d busy=1", sel, busy, cur);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_cyc(e0 + n * p + 2);
    checks++;
    if (busy !== 1'b0 || sel !== 2'd0 || q.size() != 0) begin
      errors++;
      $display("FAIL scan_end busy=%0b sel=%0d pending=%0d required busy=0 sel=0 pending=0",
               busy, sel, q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (sel !== 2'd0 || busy !== 1'b0 || bus.sample_valid !== 1'b0 || bus.sample_bit !== 1'b0 ||
        bus.sample_ch !== 2'd0 || bus.frame_done !== 1'b0 || bus.frame_parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_values sel=%0d busy=%0b sv=%0b sb=%0b sc=%0d fd=%0b fp=%0b required all 0",
               sel, busy, bus.sample_valid, bus.sample_bit, bus.sample_ch, bus.frame_done,
               bus.frame_parity);
    end
  endtask

  task automatic test_single_channel();
    run_scan(4'b0001, 0, 4'b1111, 4, 1'b0);
  endtask

  task automatic test_round_robin();
    run_scan(4'b1011, 1, 4'b0101, 7, 1'b1);
  endtask

  task automatic test_stop_mid_scan();
    run_scan(4'b1111, 2, 4'b1010, 2, 1'b0);
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    start = 1'b1; mask = 4'b0000; dwell = '0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL start_mask0 busy=%0b sel=%0d required busy=0 sel=0", busy, sel);
    end
    start = 1'b1; stop = 1'b1; mask = 4'b1111;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL start_with_stop busy=%0b sel=%0d required busy=0 sel=0", busy, sel);
    end
    wait_cyc(cyc + 10);
  endtask

  task automatic test_max_dwell();
    run_scan(4'b0100, 255, 4'b0100, 2, 1'b0);
  endtask

  task automatic test_async_reset();
    int unsigned e0;
    data = 4'b0111;
    @(negedge clk);
    start = 1'b1; mask = 4'b0111; dwell = DWELL_W'(3);
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    wait_cyc(e0 + 2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 2'd0 || busy !== 1'b0 || bus.sample_valid !== 1'b0 || bus.sample_bit !== 1'b0 ||
        bus.sample_ch !== 2'd0 || bus.frame_done !== 1'b0 || bus.frame_parity !== 1'b0) begin
      errors++;
      $display("FAIL async_reset sel=%0d busy=%0b sv=%0b sb=%0b sc=%0d fd=%0b fp=%0b required all 0",
               sel, busy, bus.sample_valid, bus.sample_bit, bus.sample_ch, bus.frame_done,
               bus.frame_parity);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(cyc + 8);
    run_scan(4'b0111, 3, 4'b0111, 3, 1'b0);
  endtask

  initial begin
    fork
      begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_channel();
        test_round_robin();
        test_stop_mid_scan();
        test_ignored_start();
        test_max_dwell();
        test_async_reset();
      end
      monitor();
      begin
        #1000000;
        checks++; errors++;
        $display("FAIL timeout cyc=%0d required completion", cyc);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Upstream channel sequencer for the 4:1 registered mux. It drives the mux's 2-bit `sel` through a round-robin scan of enabled channels and waits out the mux's one-cycle register latency plus a programmable dwell. It then captures the mux's registered `out` and presents each sample with its channel tag to downstream logic.

## Interface
- `DWELL_W`, default 8: width of the dwell input; internal counter is `DWELL_W+1` bits.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin continuous scanning; honoured only in IDLE.
- `stop` input 1: request end of scan; latched, takes effect after current sample.
- `mask` input 4: channel enables, bit n = channel n (sel value n); captured on accepted start.
- `dwell` input DWELL_W: extra settle cycles per channel; captured on accepted start.
- `mux_out` input 1: registered output of the downstream-fed mux.
- `sel` output 2: mux channel select, registered.
- `busy` output 1: high in any state other than IDLE.
- `sample_valid` output 1: one-cycle pulse, sample present.
- `sample_bit` output 1: captured `mux_out`.
- `sample_ch` output 2: channel of current sample.
- `frame_done` output 1: pulses with `sample_valid` of the last enabled channel in a frame.
- `frame_parity` output 1: XOR of all sample bits in completed frame (see Configuration).

## Operation
- States: IDLE, SETTLE, SAMPLE.
- IDLE: `start`=1, `stop`=0, `mask`!=0 -> capture `mask_q`, `dwell_q`; `sel`<=lowest enabled channel; `cnt`<=`dwell`+1; -> SETTLE. `start` with `mask`=0 or with `stop`=1: ignored, stay IDLE.
- SETTLE: `cnt` decrements each cycle; at `cnt`=0 -> SAMPLE. Duration `dwell`+2 cycles (covers mux register latency).
- SAMPLE (one cycle): at its closing edge `sample_bit`<=`mux_out`, `sample_ch`<=`sel`, `sample_valid`<=1; `frame_done`<=1 if `sel` is highest enabled channel in `mask_q`.
  - stop pending (latched or asserted this cycle) -> IDLE, `sel`<=0, clear stop latch.
  - else `sel`<=next enabled channel ascending, wrapping 3->0; `cnt`<=`dwell_q`+1; -> SETTLE.
- Single enabled channel: re-selects itself every period; `frame_done` every sample.
- `start` while busy ignored; `mask`/`dwell` changes while busy ignored until next start.
- `stop` in SETTLE: latched; scan completes current channel's sample, then IDLE.

## Timing
- Reset values: `sel`=0, `busy`=0, `sample_valid`=0, `sample_bit`=0, `sample_ch`=0, `frame_done`=0, `frame_parity`=0; state IDLE; stop latch clear.
- Start accepted at edge E0 -> `sel` valid after E0, `busy`=1 after E0.
- First `sample_valid` high in cycle after edge E0+`dwell`+3.
- Per-channel period: `dwell`+3 cycles; frame period = popcount(`mask_q`)*(`dwell`+3).
- `sample_valid`, `frame_done` high exactly one cycle.
- `busy` falls in same cycle as final `sample_valid` rises.
- `dwell`=2^DWELL_W-1 must not overflow counter (`DWELL_W+1` bits).
- Asynchronous reset mid-operation: all outputs to reset values immediately; no pending sample emitted.

## Configuration
- `MUX_SCAN_PARITY_EN` defined: running XOR of sample bits accumulates per frame; at `frame_done` edge `frame_parity`<=accumulator XOR final bit, accumulator cleared; holds until next `frame_done`; cleared on start.
- Undefined: no accumulator; `frame_parity` tied 0.

## Test plan
- `mask`=0001, `dwell`=0, mux out held 1 -> `sel`=0; `sample_valid` in cycle after E0+3, `sample_bit`=1, `sample_ch`=0, `frame_done`=1; repeats every 3 cycles.
- `mask`=1011, `dwell`=1 -> `sample_ch` sequence 0,1,3,0,1..., period 4 cycles, `frame_done` only with ch 3.
- `stop` pulsed during SETTLE of ch 1 (mask 1111) -> ch 1 sample delivered, then IDLE, `busy`=0, `sel`=0, no ch 2 sample.
- `start` with `mask`=0; then `start`+`stop` together with `mask`=1111 -> stays IDLE, `busy`=0 both times.
- `dwell`=255 (DWELL_W=8), mask 0100 -> 258-cycle period, `sel`=2 throughout.
- `rst_n` low mid-SETTLE -> all outputs 0 immediately; restart behaves as first start. With `MUX_SCAN_PARITY_EN`, mask 0111, bits 1,1,1 -> `frame_parity`=1.
